// File: rtl/imm_extend_pipe.sv
// Immediate generator: widens an instruction immediate in one of four modes
// and hands results downstream through a two-entry skid buffer.
module imm_extend_pipe #(
  parameter int DATA_W   = 32,
  parameter int IMM_W    = 16,
  parameter int BR_SHAMT = 2,
  parameter int TAG_W    = 5
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [IMM_W-1:0]  in_imm,
  input  logic [1:0]        in_mode,
  input  logic [TAG_W-1:0]  in_tag,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_imm,
  output logic [TAG_W-1:0]  out_tag
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [DATA_W-1:0] zx;
  logic [DATA_W-1:0] sx;
  logic [DATA_W-1:0] ext;

  logic [DATA_W-1:0] or_imm;
  logic [TAG_W-1:0]  or_tag;
  logic [DATA_W-1:0] sk_imm;
  logic [TAG_W-1:0]  sk_tag;

  logic in_fire;
  logic out_fire;
  logic ld_or;
  logic or_from_sk;
  logic ld_sk;

  // Size casts handle DATA_W == IMM_W without zero-width replications.
  always_comb begin
    zx  = DATA_W'(in_imm);
    sx  = DATA_W'($signed(in_imm));
    ext = zx;
    unique case (in_mode)
      2'b00:   ext = zx;
      2'b01:   ext = sx;
      2'b10:   ext = zx << (DATA_W - IMM_W);
      2'b11:   ext = sx << BR_SHAMT;
      default: ext = zx;
    endcase
  end

  // Ready depends on state alone, so no path from out_ready.
  assign in_ready  = (state != FULL);
  assign out_valid = (state != EMPTY);
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;
  assign out_imm   = or_imm;
  assign out_tag   = or_tag;

  always_comb begin
    state_nxt  = state;
    ld_or      = 1'b0;
    or_from_sk = 1'b0;
    ld_sk      = 1'b0;
    unique case (state)
      EMPTY: begin
        if (in_fire) begin
          ld_or     = 1'b1;
          state_nxt = ONE;
        end
      end
      ONE: begin
        if (in_fire && out_fire) begin
          ld_or = 1'b1;
        end else if (in_fire) begin
          ld_sk     = 1'b1;
          state_nxt = FULL;
        end else if (out_fire) begin
          state_nxt = EMPTY;
        end
      end
      FULL: begin
        if (out_fire) begin
          ld_or      = 1'b1;
          or_from_sk = 1'b1;
          state_nxt  = ONE;
        end
      end
      default: state_nxt = EMPTY;
    endcase
    if (RST || flush) begin
      state_nxt = EMPTY;
      ld_or     = 1'b0;
      ld_sk     = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= EMPTY;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge CLK) begin
    if (ld_or) begin
      or_imm <= or_from_sk ? sk_imm : ext;
      or_tag <= or_from_sk ? sk_tag : in_tag;
    end
    if (ld_sk) begin
      sk_imm <= ext;
      sk_tag <= in_tag;
    end
  end

endmodule

// File: tb/tb_imm_extend_pipe.sv
// Bench for imm_extend_pipe: vector table, corner sequences and a
// scoreboard fed from a reference extension model.
module tb_imm_extend_pipe;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_imm;
  logic [1:0]  in_mode;
  logic [4:0]  in_tag;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_imm;
  logic [4:0]  out_tag;

  int pass_cnt = 0;
  int total_cnt = 0;

  logic [36:0] sb[$];

  typedef struct {
    logic [15:0] imm;
    logic [1:0]  mode;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[5];

  imm_extend_pipe #(
    .DATA_W(32), .IMM_W(16), .BR_SHAMT(2), .TAG_W(5)
  ) dut (
    .CLK(clk),
    .RST(rst),
    .flush(flush),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_imm(in_imm),
    .in_mode(in_mode),
    .in_tag(in_tag),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_imm(out_imm),
    .out_tag(out_tag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] ref_ext(logic [15:0] imm, logic [1:0] mode);
    case (mode)
      2'd0:    return {16'h0000, imm};
      2'd1:    return {{16{imm[15]}}, imm};
      2'd2:    return {imm, 16'h0000};
      default: return {{14{imm[15]}}, imm, 2'b00};
    endcase
  endfunction

  task automatic check(string nm, logic [63:0] act, logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: inputs and outputs are stable at the falling edge,
  // so fires seen here are the ones the next rising edge commits.
  always @(negedge clk) begin
    logic [36:0] e;
    if (rst || flush) begin
      sb.delete();
    end else begin
      check("in_ready_vs_model", {63'd0, in_ready}, {63'd0, sb.size() < 2});
      check("out_valid_vs_model", {63'd0, out_valid}, {63'd0, sb.size() != 0});
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          check("sb_underflow", 64'd1, 64'd0);
        end else begin
          e = sb.pop_front();
          check("sb_tag_imm", {27'd0, out_tag, out_imm}, {27'd0, e});
        end
      end
      if (in_valid && in_ready)
        sb.push_back({in_tag, ref_ext(in_imm, in_mode)});
    end
  end

  initial begin
    vecs[0] = '{16'h8001, 2'd0, 32'h00008001};
    vecs[1] = '{16'h8001, 2'd1, 32'hFFFF8001};
    vecs[2] = '{16'h1234, 2'd2, 32'h12340000};
    vecs[3] = '{16'hFFFF, 2'd3, 32'hFFFFFFFC};
    vecs[4] = '{16'h0004, 2'd3, 32'h00000010};

    rst = 1'b1;
    flush = 1'b0;
    in_valid = 1'b0;
    in_imm = '0;
    in_mode = '0;
    in_tag = '0;
    out_ready = 1'b0;

    tick();
    tick();
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_in_ready", {63'd0, in_ready}, 64'd1);
    tick();
    check("rst_hold_out_valid", {63'd0, out_valid}, 64'd0);
    rst = 1'b0;
    tick();

    // mode sweep, back-to-back with out_ready high
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_imm = vecs[i].imm;
      in_mode = vecs[i].mode;
      in_tag = 5'(i + 1);
      tick();
      check("sweep_valid", {63'd0, out_valid}, 64'd1);
      check("sweep_imm", {32'd0, out_imm}, {32'd0, vecs[i].exp});
      check("sweep_tag", {59'd0, out_tag}, 64'(i + 1));
    end
    in_valid = 1'b0;
    tick();
    check("sweep_drain", {63'd0, out_valid}, 64'd0);

    // backpressure: third offer must stall
    out_ready = 1'b0;
    in_mode = 2'd0;
    in_valid = 1'b1;
    in_tag = 5'd1; in_imm = 16'h0011;
    tick();
    check("bp_ready_after1", {63'd0, in_ready}, 64'd1);
    in_tag = 5'd2; in_imm = 16'h0022;
    tick();
    check("bp_ready_after2", {63'd0, in_ready}, 64'd0);
    in_tag = 5'd3; in_imm = 16'h0033;
    tick();
    check("bp_hold_ready", {63'd0, in_ready}, 64'd0);
    check("bp_hold_tag", {59'd0, out_tag}, 64'd1);
    out_ready = 1'b1;
    tick();
    check("bp_tag2", {59'd0, out_tag}, 64'd2);
    check("bp_recover_ready", {63'd0, in_ready}, 64'd1);
    tick();
    in_valid = 1'b0;
    check("bp_tag3", {59'd0, out_tag}, 64'd3);
    check("bp_tag3_valid", {63'd0, out_valid}, 64'd1);
    tick();
    check("bp_empty", {63'd0, out_valid}, 64'd0);

    // streaming
    out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      in_valid = 1'b1;
      in_imm = 16'($urandom);
      in_mode = 2'($urandom);
      in_tag = 5'(i);
      tick();
      check("stream_ready", {63'd0, in_ready}, 64'd1);
      check("stream_tag", {58'd0, out_valid, out_tag}, {58'd0, 1'b1, 5'(i)});
    end
    in_valid = 1'b0;
    tick();

    // flush while FULL with a valid input present
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_mode = 2'd1;
    in_tag = 5'd10; in_imm = 16'h0A0A;
    tick();
    in_tag = 5'd11; in_imm = 16'h0B0B;
    tick();
    check("fl_full", {63'd0, in_ready}, 64'd0);
    flush = 1'b1;
    in_tag = 5'd12; in_imm = 16'h0C0C;
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    check("fl_out_valid", {63'd0, out_valid}, 64'd0);
    check("fl_in_ready", {63'd0, in_ready}, 64'd1);
    out_ready = 1'b1;
    tick();
    tick();
    check("fl_nothing_left", {63'd0, out_valid}, 64'd0);

    // reset together with flush while ONE
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_tag = 5'd20; in_imm = 16'h1111; in_mode = 2'd0;
    tick();
    in_valid = 1'b0;
    rst = 1'b1;
    flush = 1'b1;
    tick();
    check("rf_out_valid", {63'd0, out_valid}, 64'd0);
    check("rf_in_ready", {63'd0, in_ready}, 64'd1);
    rst = 1'b0;
    flush = 1'b0;
    out_ready = 1'b1;
    in_valid = 1'b1;
    in_tag = 5'd21; in_imm = 16'h8000; in_mode = 2'd3;
    tick();
    in_valid = 1'b0;
    check("rf_after_imm", {32'd0, out_imm}, 64'h00000000FFFE0000);
    check("rf_after_tag", {58'd0, out_valid, out_tag}, {58'd0, 1'b1, 5'd21});
    tick();

    // random stress
    for (int i = 0; i < 600; i++) begin
      in_valid = 1'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      flush = ($urandom_range(0, 40) == 0);
      in_imm = 16'($urandom);
      in_mode = 2'($urandom);
      in_tag = 5'($urandom);
      tick();
    end
    flush = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 10 && sb.size() != 0; i++) tick();
    tick();
    check("stress_drained", 64'(sb.size()), 64'd0);
    check("stress_out_valid", {63'd0, out_valid}, 64'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/imm_extend_pipe.md
# imm_extend_pipe

Pipelined, parametrised immediate generator for the datapath decode stage. Widens an IMM_W-bit instruction immediate to DATA_W bits in one of four modes: zero-extend, sign-extend, upper-load, or branch-offset. It carries a sideband tag alongside each result and moves results through a valid/ready handshake with a two-entry skid buffer, so decode stalls never drop or duplicate an immediate. A synchronous flush supports branch squash.

## Interface
Parameters:
- DATA_W, 32: result width. Must satisfy DATA_W >= IMM_W.
- IMM_W, 16: input immediate width.
- BR_SHAMT, 2: left shift applied in branch mode.
- TAG_W, 5: sideband tag width, e.g. destination register. Passed through unchanged.

Ports:
- CLK, input, 1: single clock. All logic is rising-edge.
- RST, input, 1: reset, synchronous and active-high.
- flush, input, 1: synchronous squash of all held entries.
- in_valid, input, 1: input request.
- in_ready, output, 1: block can accept an input this cycle.
- in_imm, input, IMM_W: raw immediate field.
- in_mode, input, 2: 00 zero, 01 sign, 10 upper, 11 branch.
- in_tag, input, TAG_W: sideband data.
- out_valid, output, 1: out_imm and out_tag are valid.
- out_ready, input, 1: consumer accepts this cycle.
- out_imm, output, DATA_W: extended immediate.
- out_tag, output, TAG_W: tag of the entry currently presented.

## Operation
Handshakes:
- Input fire = in_valid & in_ready.
- Output fire = out_valid & out_ready.

Extension arithmetic (combinational on input, registered on capture):
- Zero mode: upper DATA_W-IMM_W bits are 0.
- Sign mode: upper bits replicate in_imm[IMM_W-1].
- Upper mode: in_imm << (DATA_W-IMM_W); low bits are 0. When DATA_W == IMM_W the result equals in_imm.
- Branch mode: sign-extend, then << BR_SHAMT, truncated to DATA_W; vacated low bits are 0.

Storage:
- Output register (OR) drives out_imm and out_tag.
- Skid register (SK) holds one further {imm, tag}.
- Both hold the already-extended value; mode is not stored.

State machine:
- EMPTY: out_valid=0, in_ready=1.
- ONE: OR valid, SK empty, in_ready=1.
- FULL: OR and SK valid, in_ready=0.

Transitions (evaluated only when RST=0 and flush=0):
- EMPTY, input fire: OR <= new entry, go to ONE.
- ONE, input fire and output fire: OR <= new entry, stay in ONE.
- ONE, input fire without output fire: SK <= new entry, go to FULL.
- ONE, output fire without input fire: go to EMPTY.
- FULL, output fire: OR <= SK, go to ONE.
- All other cases: hold state and data.

Boundary rules:
- in_ready is a function of state only, never of out_ready, so there is no combinational ready path.
- Ordering is strictly FIFO, with no reordering or duplication.
- Flush has priority over any simultaneous input or output fire. Next state is EMPTY, and an input presented in the flush cycle is discarded.
- RST has priority over flush. Next state is EMPTY.
- Data registers need not be reset. out_imm and out_tag are don't-care while out_valid=0, and the bench must not check them then.

## Timing
- Reset values: out_valid=0 and in_ready=1 in the cycle after RST is sampled high, and for as long as RST stays high.
- Latency: one cycle. An input fire at edge N gives out_valid=1 with the result after edge N.
- Throughput: one result per cycle when out_ready is held high.
- Backpressure: with out_ready=0, at most two entries are accepted. in_ready falls the cycle after the second acceptance.
- Recovery: after one output fire from FULL, in_ready returns to 1 in the next cycle.
- Flush or reset mid-operation: out_valid=0 in the next cycle regardless of prior state. In-flight entries are lost.

## Test plan
All scenarios use DATA_W=32, IMM_W=16, BR_SHAMT=2.
- Mode sweep with out_ready=1:
  - 0x8001 zero -> 0x00008001.
  - 0x8001 sign -> 0xFFFF8001.
  - 0x1234 upper -> 0x12340000.
  - 0xFFFF branch -> 0xFFFFFFFC.
  - 0x0004 branch -> 0x00000010.
  - Each result appears exactly one cycle after its input fire, with its tag intact.
- Backpressure: out_ready=0, offer tags 1, 2, 3 back-to-back. Only 1 and 2 are accepted; in_ready=0 from the cycle after tag 2. Raise out_ready: out_tag sequence is 1, 2, 3, with no gaps once streaming.
- Streaming: 20 consecutive inputs with in_valid=out_ready=1. 20 outputs in 20 consecutive cycles, in order, with in_ready constantly 1.
- Flush in FULL with a simultaneous valid input: next cycle out_valid=0 and in_ready=1. The flushed entries and the input from the flush cycle never appear.
- RST asserted while in ONE with flush=1: next cycle out_valid=0 and in_ready=1. A new input afterwards returns its correct result with one-cycle latency.
- Random valid/ready stress against a FIFO reference model of the extension function: no loss, duplication, or reordering, and in_ready never depends combinationally on out_ready.
